cla_addsub_pipe: RTL
====================

Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the FP ALU mantissa and exponent datapaths. It is built from GROUP-bit lookahead blocks with a second-level group carry tree. It adds a valid/ready handshake and a configurable register depth so that it closes timing at full mantissa width. It replaces chains of 1-bit lookahead cells in the exponent-difference and mantissa add paths.

Parameters:
WIDTH, 24, operand/result width in bits (legal 4..64).
GROUP, 4, bits per lookahead group (legal 2..8; WIDTH need not be a multiple; last group is partial).
STAGES, 2, pipeline register stages between input and output (legal 1..4).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
cin  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow (optional feature)
zero  output  1  sum == 0 (optional feature)

Behaviour:
- Clocking and reset: single clock domain. Asynchronous active-low reset, synchronous release assumed upstream.
- Arithmetic: effective B = sub ? ~b : b. Effective carry-in = sub ? ~cin : cin.
  - {cout, sum} = a + effB + effCin, evaluated WIDTH+1 bits wide.
  - Add example: a=5, b=3, cin=1 -> sum=9, cout=0.
  - Sub example: a=5, b=3, cin=0 -> sum=2, cout=1.
  - Sub with borrow: a=5, b=3, cin=1 -> sum=1.
- Carry structure: per-bit G=a&effB, P=a^effB. Group G/P combined by a lookahead tree; no ripple across groups. Stage boundaries split the tree; exact split is implementer's choice. Results must be bit-exact for every STAGES value.
- Latency: exactly STAGES cycles from an accepted input beat (in_valid & in_ready) to out_valid, with no backpressure.
- Handshake: each stage holds a valid bit.
  - A stage advances when the next stage is empty or advancing. The last stage advances when out_ready=1.
  - in_ready = first stage empty or advancing. in_ready must not depend on in_valid.
  - Full throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 & out_ready=0, outputs hold stable and no beat is lost or duplicated. Pipeline fills to STAGES beats, then in_ready=0.
- Simultaneous events: accept and emit in the same cycle are allowed when full and out_ready=1.
- Data registers: may be non-reset. Only valid bits require reset.
- Reset: asynchronous, active-low. On assertion, all valid bits clear immediately and any in-flight beats are discarded.
  - Output values during reset: out_valid=0, in_ready=0, sum=0, cout=0, ovf=0, zero=0.
  - First cycle after release: in_ready=1.
- Boundaries:
  - WIDTH not a multiple of GROUP: top partial group is handled correctly.
  - Wrap-around: all-ones + 1 gives sum=0, cout=1.
  - Reset mid-stall drops all beats.

Optional Feature:
CLA_STATUS_FLAGS_EN.
- Defined: ovf = carry into MSB XOR carry out of MSB; zero = (sum==0). Both are registered alongside sum with the same latency and stall behaviour.
- Undefined: ovf and zero ports remain present and are tied to 0. No flag logic is synthesised.

Test Plan:
WIDTH=24, STAGES=2: a=0x000005, b=0x000003, sub=0, cin=1 -> after 2 cycles out_valid=1, sum=0x000009, cout=0.
sub=1, a=0x000003, b=0x000005, cin=0 -> sum=0xFFFFFE, cout=0. With CLA_STATUS_FLAGS_EN: ovf=0, zero=0.
a=0xFFFFFF, b=0x000001, sub=0, cin=0 -> sum=0x000000, cout=1, zero=1. a=0x7FFFFF, b=0x000001 -> sum=0x800000, ovf=1.
Stream 10 random beats with out_ready toggling 1,0,0,1,…: every result matches the reference model in order, with none lost or duplicated. in_ready=0 while 2 beats are held and out_ready=0.
Assert rst_n low mid-stream with 2 beats in flight -> out_valid=0 immediately. After release, in_ready=1 and no stale beat emerges.
Sweep WIDTH=13, GROUP=4, STAGES=1,3,4 with exhaustive low-bit plus random operands -> bit-exact results; latency equals STAGES.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_STATUS_FLAGS_EN to compute the ovf/zero flags; otherwise they are tied to 0.

module cla_grp_gp #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] i_g,
  input  logic [GW-1:0] i_p,
  output logic          o_gg,
  output logic          o_gp
);
  always_comb begin
    o_gg = 1'b0;
    for (int j = 0; j < GW; j++) o_gg = i_g[j] | (i_p[j] & o_gg);
  end
  assign o_gp = &i_p;
endmodule

module cla_grp_sum #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] i_g,
  input  logic [GW-1:0] i_p,
  input  logic          i_c,
  output logic [GW-1:0] o_s
);
  logic w_c;
  always_comb begin
    o_s = '0;
    w_c = i_c;
    for (int j = 0; j < GW; j++) begin
      o_s[j] = i_p[j] ^ w_c;
      w_c    = i_g[j] | (i_p[j] & w_c);
    end
  end
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH  = 24,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int LV = (NG > 1) ? $clog2(NG) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic             c0;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic [WIDTH-1:0]  w_effb, w_g, w_p, w_sum;
  logic [NG-1:0]     w_gg, w_gp;
  logic [NG:0]       w_gc;
  logic [NG-1:0]     w_tg [LV+1];
  logic [NG-1:0]     w_tp [LV+1];
  s1_t               w_s1, r_s1;
  res_t              w_res, w_out;
  logic [STAGES:1]   r_vld_pipe;
  logic [STAGES+1:1] w_en;
  logic              w_acc;

  // Input side: per-bit and per-group generate/propagate.
  assign w_effb = sub ? ~b : b;
  assign w_g    = a & w_effb;
  assign w_p    = a ^ w_effb;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO = k * GROUP;
    localparam int GW = (k == NG - 1) ? WIDTH - LO : GROUP;
    cla_grp_gp #(.GW(GW)) u_gp (
      .i_g (w_g[LO +: GW]),
      .i_p (w_p[LO +: GW]),
      .o_gg(w_gg[k]),
      .o_gp(w_gp[k])
    );
    cla_grp_sum #(.GW(GW)) u_sum (
      .i_g(r_s1.g[LO +: GW]),
      .i_p(r_s1.p[LO +: GW]),
      .i_c(w_gc[k]),
      .o_s(w_sum[LO +: GW])
    );
  end

  always_comb begin
    w_s1.g  = w_g;
    w_s1.p  = w_p;
    w_s1.gg = w_gg;
    w_s1.gp = w_gp;
    w_s1.c0 = sub ^ cin;
  end

  // Kogge-Stone prefix over group G/P after the first register; no ripple between groups.
  always_comb begin
    w_tg[0] = r_s1.gg;
    w_tp[0] = r_s1.gp;
    for (int l = 0; l < LV; l++) begin
      for (int k = 0; k < NG; k++) begin
        if (k >= (1 << l)) begin
          w_tg[l+1][k] = w_tg[l][k] | (w_tp[l][k] & w_tg[l][k-(1<<l)]);
          w_tp[l+1][k] = w_tp[l][k] & w_tp[l][k-(1<<l)];
        end else begin
          w_tg[l+1][k] = w_tg[l][k];
          w_tp[l+1][k] = w_tp[l][k];
        end
      end
    end
    w_gc[0] = r_s1.c0;
    for (int k = 0; k < NG; k++) w_gc[k+1] = w_tg[LV][k] | (w_tp[LV][k] & r_s1.c0);
  end

  always_comb begin
    w_res.sum  = w_sum;
    w_res.cout = w_gc[NG];
`ifdef CLA_STATUS_FLAGS_EN
    // Carry into the MSB is recovered as sum ^ propagate at that bit.
    w_res.ovf  = w_sum[WIDTH-1] ^ r_s1.p[WIDTH-1] ^ w_gc[NG];
    w_res.zero = ~|w_sum;
`else
    w_res.ovf  = 1'b0;
    w_res.zero = 1'b0;
`endif
  end

  // A stage may load when it is empty or its successor is loading.
  always_comb begin
    w_en[STAGES+1] = out_ready;
    for (int s = STAGES; s >= 1; s--) w_en[s] = ~r_vld_pipe[s] | w_en[s+1];
  end

  assign in_ready = rst_n & w_en[1];
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_en[1]) r_vld_pipe[1] <= w_acc;
      for (int s = 2; s <= STAGES; s++)
        if (w_en[s]) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_s1 <= w_s1;
  end

  if (STAGES > 1) begin : g_rpipe
    res_t r_res [2:STAGES];
    always_ff @(posedge clk) begin
      if (w_en[2]) r_res[2] <= w_res;
      for (int s = 3; s <= STAGES; s++)
        if (w_en[s]) r_res[s] <= r_res[s-1];
    end
    assign w_out = r_res[STAGES];
  end else begin : g_rcomb
    assign w_out = w_res;
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign sum       = out_valid ? w_out.sum : '0;
  assign cout      = out_valid & w_out.cout;
  assign ovf       = out_valid & w_out.ovf;
  assign zero      = out_valid & w_out.zero;
endmodule
